// File: rtl/i2c_bus_resolver_pkg.sv
// Shared types and sizing helpers for the open-drain I2C bus resolver.
package i2c_bus_pkg;

  typedef enum logic {I2C_LOW = 1'b0, I2C_HIGH = 1'b1} line_t;

  localparam int DEF_RISE_CYC = 4;
  localparam int DEF_FILT_LEN = 3;

  // Counter width for a counter that must hold 0..n; never less than 1 bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/i2c_bus_resolver_if.sv
// Pad-side bundle of the I2C bus resolver: per-device drivers in, resolved lines and flags out.
interface i2c_bus_resolver_if #(
  parameter int N_DEV  = 2,
  parameter int TOUT_W = 16
);
  logic [N_DEV-1:0]  SCL_PAD_O;
  logic [N_DEV-1:0]  SCL_PADOEN_O;
  logic [N_DEV-1:0]  SDA_PAD_O;
  logic [N_DEV-1:0]  SDA_PADOEN_O;
  logic [TOUT_W-1:0] TOUT_LIM_I;
  logic              SCL_PAD_I;
  logic              SDA_PAD_I;
  logic              BUS_BUSY_O;
  logic              START_O;
  logic              STOP_O;
  logic [N_DEV-1:0]  ARB_LOST_O;
  logic              STRETCH_O;
  logic              TOUT_O;

  modport master (
    output SCL_PAD_O, SCL_PADOEN_O, SDA_PAD_O, SDA_PADOEN_O, TOUT_LIM_I,
    input  SCL_PAD_I, SDA_PAD_I, BUS_BUSY_O, START_O, STOP_O, ARB_LOST_O,
           STRETCH_O, TOUT_O
  );

  modport slave (
    input  SCL_PAD_O, SCL_PADOEN_O, SDA_PAD_O, SDA_PADOEN_O, TOUT_LIM_I,
    output SCL_PAD_I, SDA_PAD_I, BUS_BUSY_O, START_O, STOP_O, ARB_LOST_O,
           STRETCH_O, TOUT_O
  );
endinterface

// File: rtl/i2c_bus_resolver_line.sv
// One open-drain line: wired-AND with finite pull-up rise time, then a
// consecutive-sample glitch filter with edge strobes on the filtered level.
module i2c_line_model
  import i2c_bus_pkg::*;
#(
  parameter int N_DEV    = 2,
  parameter int RISE_CYC = DEF_RISE_CYC,
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [N_DEV-1:0] pull,
  output logic             line,
  output logic             flt,
  output logic             rise,
  output logic             fall
);
  localparam int RW = cnt_w(RISE_CYC);
  localparam int FW = cnt_w(FILT_LEN);
  localparam logic [RW-1:0] RISE_MAX  = RW'(RISE_CYC);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

  logic [RW-1:0] rise_cnt;
  logic [FW-1:0] filt_cnt;
  line_t         line_q, flt_q, flt_d;

  // Line only goes high once the released period has run its full rise time.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      line_q   <= I2C_HIGH;
      rise_cnt <= '0;
    end else if (|pull) begin
      line_q   <= I2C_LOW;
      rise_cnt <= '0;
    end else if (rise_cnt == RISE_MAX) begin
      line_q   <= I2C_HIGH;
    end else begin
      rise_cnt <= rise_cnt + 1'b1;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      flt_q    <= I2C_HIGH;
      flt_d    <= I2C_HIGH;
      filt_cnt <= '0;
    end else begin
      flt_d <= flt_q;
      if (line_q == flt_q) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        flt_q    <= line_q;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign line = line_q;
  assign flt  = flt_q;
  assign rise = (flt_q == I2C_HIGH) && (flt_d == I2C_LOW);
  assign fall = (flt_q == I2C_LOW)  && (flt_d == I2C_HIGH);

endmodule

// File: rtl/i2c_bus_resolver.sv
// N-device open-drain I2C bus: resolved SCL/SDA, START/STOP/busy, arbitration loss.
// Optional clock-stretch timeout monitor enabled by defining I2C_STRETCH_TOUT_EN.
module i2c_bus_resolver
  import i2c_bus_pkg::*;
#(
  parameter int N_DEV    = 2,
  parameter int RISE_CYC = DEF_RISE_CYC,
  parameter int FILT_LEN = DEF_FILT_LEN,
  parameter int TOUT_W   = 16
) (
  input  logic              WB_CLK_I,
  input  logic              ARST_I,
  i2c_bus_resolver_if.slave bus
);
  logic [N_DEV-1:0] scl_pull, sda_pull, arb_lost;
  logic scl_line, fscl, scl_rise, scl_fall;
  logic sda_line, fsda, sda_rise, sda_fall;
  logic start_cond, stop_cond, start_q, stop_q, busy;

  // A device driving 1 with its enable active is still just releasing the line.
  assign scl_pull = ~bus.SCL_PADOEN_O & ~bus.SCL_PAD_O;
  assign sda_pull = ~bus.SDA_PADOEN_O & ~bus.SDA_PAD_O;

  i2c_line_model #(.N_DEV(N_DEV), .RISE_CYC(RISE_CYC), .FILT_LEN(FILT_LEN)) u_scl (
    .gclk(WB_CLK_I), .grst_n(ARST_I), .pull(scl_pull),
    .line(scl_line), .flt(fscl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_model #(.N_DEV(N_DEV), .RISE_CYC(RISE_CYC), .FILT_LEN(FILT_LEN)) u_sda (
    .gclk(WB_CLK_I), .grst_n(ARST_I), .pull(sda_pull),
    .line(sda_line), .flt(fsda), .rise(sda_rise), .fall(sda_fall)
  );

  // SDA edges only count as conditions while SCL is high and did not move this cycle.
  assign start_cond = sda_fall && fscl && !scl_rise && !scl_fall;
  assign stop_cond  = sda_rise && fscl && !scl_rise && !scl_fall;

  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      busy     <= 1'b0;
      arb_lost <= '0;
    end else begin
      start_q <= start_cond;
      stop_q  <= stop_cond;
      if (start_cond)     busy <= 1'b1;
      else if (stop_cond) busy <= 1'b0;
      if (start_cond || stop_cond)
        arb_lost <= '0;
      else if (scl_rise && busy)
        arb_lost <= arb_lost | (~sda_pull & {N_DEV{~fsda}});
    end
  end

  assign bus.SCL_PAD_I  = scl_line;
  assign bus.SDA_PAD_I  = sda_line;
  assign bus.BUS_BUSY_O = busy;
  assign bus.START_O    = start_q;
  assign bus.STOP_O     = stop_q;
  assign bus.ARB_LOST_O = arb_lost;

`ifdef I2C_STRETCH_TOUT_EN
  logic              stretch, tout_q;
  logic [TOUT_W-1:0] st_cnt;

  // Stretching means someone let go of SCL but the line is still held low.
  assign stretch = !scl_line && |(~scl_pull);

  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      st_cnt <= '0;
      tout_q <= 1'b0;
    end else begin
      if (!stretch)     st_cnt <= '0;
      else if (!&st_cnt) st_cnt <= st_cnt + 1'b1;
      if (stop_cond)
        tout_q <= 1'b0;
      else if (bus.TOUT_LIM_I != '0 && st_cnt == bus.TOUT_LIM_I)
        tout_q <= 1'b1;
    end
  end

  assign bus.STRETCH_O = stretch;
  assign bus.TOUT_O    = tout_q;
`else
  logic unused_lim;
  assign unused_lim    = ^bus.TOUT_LIM_I;
  assign bus.STRETCH_O = 1'b0;
  assign bus.TOUT_O    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_resolver.sv
// Directed bench for i2c_bus_resolver; START/STOP pulses are scoreboarded.
module tb_i2c_bus_resolver;
  typedef enum int {EV_START = 1, EV_STOP = 2} ev_t;

  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  i2c_bus_resolver_if #(.N_DEV(2), .TOUT_W(16)) bus ();

  i2c_bus_resolver #(.N_DEV(2), .RISE_CYC(4), .FILT_LEN(3), .TOUT_W(16)) dut (
    .WB_CLK_I(clk),
    .ARST_I  (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sda(input int d, input logic pull);
    bus.SDA_PAD_O[d]    = 1'b0;
    bus.SDA_PADOEN_O[d] = ~pull;
  endtask

  task automatic scl(input int d, input logic pull);
    bus.SCL_PAD_O[d]    = 1'b0;
    bus.SCL_PADOEN_O[d] = ~pull;
  endtask

  // Scoreboard: every START/STOP pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t got;
    if (bus.START_O === 1'b1 || bus.STOP_O === 1'b1) begin
      got = (bus.START_O === 1'b1) ? EV_START : EV_STOP;
      chk("ev_not_both", {bus.START_O, bus.STOP_O} == 2'b11, 0);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_event observed=%0d expected=none", got);
      end
      if (exp_q.size() != 0) chk("ev_kind", got, exp_q.pop_front());
      chk("ev_busy", bus.BUS_BUSY_O, got == EV_START);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.SCL_PAD_O = '0; bus.SCL_PADOEN_O = '1;
    bus.SDA_PAD_O = '0; bus.SDA_PADOEN_O = '1;
    bus.TOUT_LIM_I = '0;

    // Reset held while dev0 pulls SDA
    sda(0, 1);
    tick(2);
    chk("rst_scl", bus.SCL_PAD_I, 1);
    chk("rst_sda", bus.SDA_PAD_I, 1);
    chk("rst_busy", bus.BUS_BUSY_O, 0);
    chk("rst_arb", bus.ARB_LOST_O, 0);
    chk("rst_pulses", {bus.START_O, bus.STOP_O}, 0);
    chk("rst_stretch", {bus.STRETCH_O, bus.TOUT_O}, 0);
    rst_n = 1'b1;
    exp_q.push_back(EV_START);
    chk("rel_sda_hold", bus.SDA_PAD_I, 1);
    tick(1);
    chk("rel_sda_fall", bus.SDA_PAD_I, 0);
    chk("rel_busy", bus.BUS_BUSY_O, 0);
    chk("rel_start", bus.START_O, 0);
    tick(10);
    chk("rel_busy_on", bus.BUS_BUSY_O, 1);
    sda(0, 0);
    exp_q.push_back(EV_STOP);
    tick(15);
    chk("rel_busy_off", bus.BUS_BUSY_O, 0);

    // Rise time: dev1 pulls SDA 10 cycles
    sda(1, 1);
    exp_q.push_back(EV_START);
    tick(1);
    chk("rise_fall_lat", bus.SDA_PAD_I, 0);
    tick(9);
    chk("rise_busy", bus.BUS_BUSY_O, 1);
    sda(1, 0);
    exp_q.push_back(EV_STOP);
    tick(4);
    chk("rise_early", bus.SDA_PAD_I, 0);
    tick(1);
    chk("rise_exact", bus.SDA_PAD_I, 1);
    tick(10);
    chk("rise_idle", bus.BUS_BUSY_O, 0);

    // Two-sample high glitch on SDA while busy must not look like a STOP
    sda(0, 1);
    exp_q.push_back(EV_START);
    tick(10);
    sda(0, 0);
    tick(5);
    chk("glitch_line_hi", bus.SDA_PAD_I, 1);
    tick(1);
    sda(0, 1);
    tick(1);
    chk("glitch_line_lo", bus.SDA_PAD_I, 0);
    tick(10);
    chk("glitch_busy", bus.BUS_BUSY_O, 1);
    sda(0, 0);
    exp_q.push_back(EV_STOP);
    tick(15);
    chk("glitch_idle", bus.BUS_BUSY_O, 0);

    // Arbitration: dev0 lets SDA go while dev1 holds it low, then SCL rises
    sda(0, 1);
    exp_q.push_back(EV_START);
    tick(10);
    scl(0, 1);
    tick(10);
    sda(0, 0);
    sda(1, 1);
    tick(5);
    scl(0, 0);
    tick(5);
    chk("arb_pre", bus.ARB_LOST_O, 2'b00);
    tick(10);
    chk("arb_set", bus.ARB_LOST_O, 2'b01);
    sda(1, 0);
    exp_q.push_back(EV_STOP);
    tick(15);
    chk("arb_clr", bus.ARB_LOST_O, 2'b00);
    chk("arb_idle", bus.BUS_BUSY_O, 0);

    // Repeated START with no STOP between
    sda(0, 1);
    exp_q.push_back(EV_START);
    tick(10);
    scl(0, 1);
    tick(10);
    sda(0, 0);
    tick(15);
    scl(0, 0);
    tick(15);
    chk("rs_arb", bus.ARB_LOST_O, 2'b00);
    chk("rs_busy_mid", bus.BUS_BUSY_O, 1);
`ifdef I2C_STRETCH_TOUT_EN
    chk("tout_disabled", bus.TOUT_O, 0);
`endif
    sda(0, 1);
    exp_q.push_back(EV_START);
    tick(10);
    chk("rs_busy", bus.BUS_BUSY_O, 1);
    sda(0, 0);
    exp_q.push_back(EV_STOP);
    tick(15);
    chk("rs_idle", bus.BUS_BUSY_O, 0);

    // Stretch: dev1 holds SCL low, dev0 drives 1 with enable on (released)
    bus.TOUT_LIM_I = 16'd20;
    bus.SCL_PAD_O[0] = 1'b1;
    bus.SCL_PADOEN_O[0] = 1'b0;
    scl(1, 1);
    tick(10);
    chk("st_scl_low", bus.SCL_PAD_I, 0);
`ifdef I2C_STRETCH_TOUT_EN
    chk("st_stretch", bus.STRETCH_O, 1);
    chk("st_tout_early", bus.TOUT_O, 0);
`else
    chk("st_stretch_off", bus.STRETCH_O, 0);
    chk("st_tout_off", bus.TOUT_O, 0);
`endif
    tick(20);
`ifdef I2C_STRETCH_TOUT_EN
    chk("st_tout", bus.TOUT_O, 1);
`else
    chk("st_tout_off2", bus.TOUT_O, 0);
`endif
    scl(1, 0);
    scl(0, 0);
    tick(15);
    chk("st_scl_high", bus.SCL_PAD_I, 1);
    chk("st_stretch_end", bus.STRETCH_O, 0);
`ifdef I2C_STRETCH_TOUT_EN
    chk("st_tout_sticky", bus.TOUT_O, 1);
`endif

    // Reset in the middle of a transfer clears state asynchronously
    sda(0, 1);
    exp_q.push_back(EV_START);
    tick(10);
    chk("mo_busy", bus.BUS_BUSY_O, 1);
    rst_n = 1'b0;
    #1;
    chk("mo_busy_async", bus.BUS_BUSY_O, 0);
    chk("mo_sda_async", bus.SDA_PAD_I, 1);
    chk("mo_tout_async", bus.TOUT_O, 0);
    tick(2);
    sda(0, 0);
    rst_n = 1'b1;
    tick(10);
    chk("mo_idle", bus.BUS_BUSY_O, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
